// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide stage: op encodings, FSM states, default widths.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = 6;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StCalc,
        StFix,
        StDone
    } md_state_e;

    // op[0] clear selects the signed variant of both MULT and DIV.
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath with sign handling and result fixup.
module muldiv_datapath
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             prep,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   b_raw_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_res_q;
    logic               neg_rem_q;

    logic               is_signed;
    logic               is_div;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mult_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign is_signed = md_is_signed(op_q);
    assign is_div    = md_is_div(op_q);
    assign div_zero  = (b_raw_q == '0);

    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign mag_a = (is_signed && a_raw_q[WIDTH-1]) ? -a_raw_q : a_raw_q;
    assign mag_b = (is_signed && b_raw_q[WIDTH-1]) ? -b_raw_q : b_raw_q;

    always_comb begin
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? divisor_q : '0)};
        mult_next = {add_sum, acc_q[WIDTH-1:1]};

        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, divisor_q};
        if (diff[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= MD_MULT;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            divisor_q <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (load) begin
            op_q    <= op;
            a_raw_q <= operand_a;
            b_raw_q <= operand_b;
        end else if (prep) begin
            divisor_q <= mag_b;
            acc_q     <= {{WIDTH{1'b0}}, mag_a};
            neg_res_q <= is_signed & (a_raw_q[WIDTH-1] ^ b_raw_q[WIDTH-1]);
            neg_rem_q <= is_signed & a_raw_q[WIDTH-1];
        end else if (step) begin
            acc_q <= is_div ? div_next : mult_next;
        end
    end

    // After CALC: multiply leaves the product in acc_q, divide leaves {remainder, quotient}.
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = a_raw_q;
            res_lo = '1;
        end else begin
            res_hi = neg_rem_q ? -rem : rem;
            res_lo = neg_res_q ? -quo : quo;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: control FSM, iteration counter and architectural HI/LO.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dp_load;
    logic             dp_prep;
    logic             dp_step;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dp_load = 1'b0;
        dp_prep = 1'b0;
        dp_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dp_load = 1'b1;
                    state_d = StPrep;
                end
            end
            StPrep: begin
                dp_prep = 1'b1;
                state_d = StCalc;
            end
            StCalc: begin
                dp_step = 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StPrep) begin
            cnt_q <= '0;
        end else if (state_q == StCalc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // MTHI/MTLO only land in IDLE; a result written in FIX always wins over them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == StFix) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (state_q == StIdle) begin
            if (hi_we) begin
                hi_q <= wdata;
            end
            if (lo_we) begin
                lo_q <= wdata;
            end
        end
    end

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (dp_load),
        .prep      (dp_prep),
        .step      (dp_step),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, protocol cases and random ops.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks;
    int n_errors;

    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero like the ISA.
    task automatic model(input logic [1:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r_hi, output logic [W-1:0] r_lo);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        case (m_op)
            2'b00: begin
                sp = sa * sb;
                up = sp;
                r_hi = up[63:32];
                r_lo = up[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                r_hi = up[63:32];
                r_lo = up[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    r_hi = a;
                    r_lo = '1;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    up = sq;
                    r_lo = up[31:0];
                    up = sr;
                    r_hi = up[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    r_hi = a;
                    r_lo = '1;
                end else begin
                    r_lo = a / b;
                    r_hi = a % b;
                end
            end
        endcase
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // mode 0: plain op; 1: start + MTHI pulsed mid-op; 2: reset asserted mid-op.
    task automatic run_op(input string tag, input logic [1:0] m_op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int mode);
        logic [W-1:0] r_hi, r_lo, old_hi, old_lo;
        int           cycles, pulses;
        bit           finished;
        model(m_op, a, b, r_hi, r_lo);
        old_hi   = exp_hi;
        old_lo   = exp_lo;
        cycles   = 0;
        pulses   = 0;
        finished = 0;
        @(negedge clk);
        start     = 1'b1;
        op        = m_op;
        operand_a = a;
        operand_b = b;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                start     = 1'b0;
                op        = 2'($urandom);
                operand_a = W'($urandom);
                operand_b = W'($urandom);
                check_val({tag, " busy_after_start"}, W'(busy), W'(1));
            end
            if (cycles == 5) begin
                check_val({tag, " hi_held"}, hi, old_hi);
                check_val({tag, " lo_held"}, lo, old_lo);
            end
            if (mode == 1 && cycles == 10) begin
                start = 1'b1;
                hi_we = 1'b1;
                wdata = 32'h0000_AAAA;
            end
            if (mode == 1 && cycles == 11) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            if (mode == 2 && cycles == 20) begin
                rst_n = 1'b0;
                #1;
                check_val({tag, " rst_busy"}, W'(busy), W'(0));
                check_val({tag, " rst_done"}, W'(done), W'(0));
                check_val({tag, " rst_hi"}, hi, 32'h0);
                check_val({tag, " rst_lo"}, lo, 32'h0);
                exp_hi = '0;
                exp_lo = '0;
                @(posedge clk);
                #1;
                check_val({tag, " rst_no_done"}, W'(done), W'(0));
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    check_val({tag, " latency"}, W'(cycles), W'(W + 3));
                    check_val({tag, " hi"}, hi, r_hi);
                    check_val({tag, " lo"}, lo, r_lo);
                    check_val({tag, " busy_in_done"}, W'(busy), W'(1));
                end
            end
            if (!busy) begin
                finished = 1;
                break;
            end
        end
        check_val({tag, " finished"}, W'(finished), W'(1));
        check_val({tag, " done_pulses"}, W'(pulses), W'(1));
        exp_hi = r_hi;
        exp_lo = r_lo;
        // A start seen while busy must not have been queued.
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, " idle_after"}, W'(busy), W'(0));
        check_val({tag, " hi_stable"}, hi, exp_hi);
        check_val({tag, " lo_stable"}, lo, exp_lo);
    endtask

    task automatic write_hilo(input string tag, input logic hw, input logic lw,
                              input logic [W-1:0] data);
        @(negedge clk);
        hi_we = hw;
        lo_we = lw;
        wdata = data;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hw) exp_hi = data;
        if (lw) exp_lo = data;
        check_val({tag, " hi"}, hi, exp_hi);
        check_val({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = '0;
        exp_hi    = '0;
        exp_lo    = '0;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset busy", W'(busy), W'(0));
        check_val("reset done", W'(done), W'(0));
        check_val("reset hi", hi, 32'h0);
        check_val("reset lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h7, 0);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h2, 0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
        run_op("divu_by0", 2'b11, 32'h1234, 32'h0, 0);
        run_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'h0, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mult_min_m1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("protocol", 2'b11, 32'd1000, 32'd33, 1);

        write_hilo("mtlo", 1'b0, 1'b1, 32'h55);
        write_hilo("mthi", 1'b1, 1'b0, 32'h1357_9BDF);
        write_hilo("mthilo", 1'b1, 1'b1, 32'hCAFE_F00D);

        run_op("reset_mid", 2'b11, 32'hDEAD_BEEF, 32'h11, 2);
        run_op("after_reset", 2'b11, 32'hDEAD_BEEF, 32'h11, 0);

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = pick();
            r_b  = pick();
            run_op($sformatf("rand%0d", i), r_op, r_a, r_b, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide stage directly downstream of the ALU operand-select mux.
- Consumes operand A from the register file and operand B from the mux output; executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Holds the architectural HI/LO registers, which are also writable via MTHI/MTLO.
- Sequencing is driven by the multicycle control FSM through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  input  WIDTH  multiplicand / dividend (rs).
- operand_b  input  WIDTH  multiplier / divisor (from operand-select mux).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal registers cleared. Asserting reset mid-operation aborts the operation with no result written.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0: latch op and operands, go to PREP, busy=1.
  - start=0: stay in IDLE.
- PREP (1 cycle):
  - Signed ops: take magnitudes of both operands; record result sign and remainder sign (dividend sign).
  - Unsigned ops: pass operands through.
  - Clear counter.
- CALC (WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: shift-add, 1 bit per cycle, 2*WIDTH product register.
  - Divide: restoring division, 1 quotient bit per cycle.
  - Exit to FIX when counter==WIDTH-1.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - MULT: product negated if signs differ.
  - DIV: quotient negated if signs differ; remainder takes dividend sign.
  - Write hi/lo at this edge (product: hi=upper, lo=lower; divide: lo=quotient, hi=remainder).
- DONE (1 cycle): done=1, busy=1; next edge -> IDLE with busy=0.
- Latency: start sampled at E0 -> done high in the cycle after edge E0+WIDTH+2 (35 cycles for WIDTH=32). hi/lo are stable from that cycle.
- Boundary rules:
  - start while busy is ignored; no queueing.
  - hi_we/lo_we while busy are ignored; hi/lo are held constant from PREP through the FIX write.
  - hi_we/lo_we in IDLE write on that edge. If start is sampled on the same edge, both take effect; the later operation result overwrites.
  - hi_we and lo_we together write wdata to both registers.
  - Divide by zero (signed or unsigned): full latency; lo=all ones, hi=original operand_a unmodified; no sign fixup.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
  - MULT with 0x80000000 operands: magnitude computed as an unsigned WIDTH-bit value; the result must match the exact 64-bit signed product.
  - Operands are latched at E0; input changes after E0 have no effect.

Decomposition:
- Shared package (mips_pkg):
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - state encoding IDLE/PREP/CALC/FIX/DONE.
  - WIDTH default.
- One natural sub-module: muldiv_datapath. It holds the shift registers, add/subtract step and sign fixup. The top module keeps the FSM, counter and HI/LO registers.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 35 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001, busy low next cycle.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- Protocol check:
  - Pulse start again, plus hi_we=1 wdata=0xAAAA, at cycle 10 of an operation -> both ignored; result unchanged; exactly one done pulse.
  - In IDLE, lo_we=1 wdata=0x55 -> lo=0x55 next cycle.
- Drive rst_n low at cycle 20 of a DIVU -> hi=lo=0, busy=0 immediately (async); no done pulse. A subsequent start completes normally.
